// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared ids, direction codes, geometry and home positions for the sprite scheduler
package sprite_pkg;

  localparam int NUM_SPRITES = 5;
  localparam int X_W         = 11;
  localparam int Y_W         = 10;
  localparam int DIR_W       = 4;
  localparam int ID_W        = 3;

  typedef enum logic [ID_W-1:0] {
    SPR_PACMAN = 3'd0,
    SPR_BLINKY = 3'd1,
    SPR_PINKY  = 3'd2,
    SPR_INKY   = 3'd3,
    SPR_CLYDE  = 3'd4
  } sprite_id_e;

  localparam logic [DIR_W-1:0] DIR_STAY = 4'b0000;
  localparam logic [DIR_W-1:0] DIR_R    = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_U    = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_D    = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_L    = 4'b1000;

  localparam int ORIGIN_X   = 336;
  localparam int ORIGIN_Y   = 27;
  localparam int TILE_PX    = 16;
  localparam int TILE_SHIFT = $clog2(TILE_PX);
  localparam int CENTRE_OFF = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } sched_state_e;

  function automatic logic [X_W-1:0] home_x(input int k);
    case (k)
      0:       home_x = 11'd1367;
      1:       home_x = 11'd983;
      2:       home_x = 11'd967;
      3:       home_x = 11'd935;
      default: home_x = 11'd999;
    endcase
  endfunction

  function automatic logic [Y_W-1:0] home_y(input int k);
    case (k)
      0:       home_y = 10'd306;
      1:       home_y = 10'd210;
      default: home_y = 10'd258;
    endcase
  endfunction

  // Tile index of a sprite centre; positions left of / above the maze simply wrap.
  function automatic logic [X_W-1:0] tile_x(input logic [X_W-1:0] x);
    tile_x = (x - X_W'(ORIGIN_X + CENTRE_OFF)) >> TILE_SHIFT;
  endfunction

  function automatic logic [Y_W-1:0] tile_y(input logic [Y_W-1:0] y);
    tile_y = (y - Y_W'(ORIGIN_Y + CENTRE_OFF)) >> TILE_SHIFT;
  endfunction

endpackage

// File: rtl/sprite_pos_bank.sv
// rtl/sprite_pos_bank.sv - per-sprite position register file with one write port and bulk home load
// Ports: clk, rst_n (async active-low, loads homes); i_home_load loads all homes (beats i_we);
//        i_we/i_wr_idx/i_wr_x/i_wr_y single-entry write; o_pos_x/o_pos_y flat readout, sprite k at slice k.
module sprite_pos_bank
  import sprite_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_home_load,
  input  logic                         i_we,
  input  logic [ID_W-1:0]              i_wr_idx,
  input  logic [X_W-1:0]               i_wr_x,
  input  logic [Y_W-1:0]               i_wr_y,
  output logic [NUM_SPRITES*X_W-1:0]   o_pos_x,
  output logic [NUM_SPRITES*Y_W-1:0]   o_pos_y
);

  logic [X_W-1:0] r_x [NUM_SPRITES];
  logic [Y_W-1:0] r_y [NUM_SPRITES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        r_x[k] <= home_x(k);
        r_y[k] <= home_y(k);
      end
    end else if (i_home_load) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        r_x[k] <= home_x(k);
        r_y[k] <= home_y(k);
      end
    end else if (i_we) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (i_wr_idx == ID_W'(k)) begin
          r_x[k] <= i_wr_x;
          r_y[k] <= i_wr_y;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_flat
    assign o_pos_x[k*X_W +: X_W] = r_x[k];
    assign o_pos_y[k*Y_W +: Y_W] = r_y[k];
  end

endmodule

// File: rtl/sprite_move_scheduler.sv
// rtl/sprite_move_scheduler.sv - sweeps all sprites through one shared position update unit per game tick
// Optional feature macro: SPRITE_COLLISION_EN (adds a CHECK state and registered pacman/ghost tile collision).
// Ports: clk, rst_n (async active-low); tick starts a sweep; respawn returns all sprites home;
//        dir_in packed one-hot dirs; upd_pos_x/upd_pos_y/upd_dir/upd_sprite operands to the update unit;
//        upd_new_x/upd_new_y results from it; pos_x/pos_y packed bank; busy, done, overrun, collision status.
module sprite_move_scheduler
  import sprite_pkg::*;
#(
  parameter int UPD_LATENCY = 1
)
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tick,
  input  logic                             respawn,
  input  logic [NUM_SPRITES*DIR_W-1:0]     dir_in,
  output logic [X_W-1:0]                   upd_pos_x,
  output logic [Y_W-1:0]                   upd_pos_y,
  output logic [DIR_W-1:0]                 upd_dir,
  output logic [ID_W-1:0]                  upd_sprite,
  input  logic [X_W-1:0]                   upd_new_x,
  input  logic [Y_W-1:0]                   upd_new_y,
  output logic [NUM_SPRITES*X_W-1:0]       pos_x,
  output logic [NUM_SPRITES*Y_W-1:0]       pos_y,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun,
  output logic [NUM_SPRITES-2:0]           collision
);

  localparam int              CNT_W    = (UPD_LATENCY > 1) ? $clog2(UPD_LATENCY) : 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SPRITES - 1);

  sched_state_e                 r_state, w_next;
  logic [ID_W-1:0]              r_idx;
  logic [CNT_W-1:0]             r_cnt;
  logic [NUM_SPRITES*DIR_W-1:0] r_snap;
  logic                         r_pend;
  logic                         w_we;
  logic                         w_home;
  logic [NUM_SPRITES*X_W-1:0]   w_pos_x;
  logic [NUM_SPRITES*Y_W-1:0]   w_pos_y;

  sprite_pos_bank u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_home_load (w_home),
    .i_we        (w_we),
    .i_wr_idx    (r_idx),
    .i_wr_x      (upd_new_x),
    .i_wr_y      (upd_new_y),
    .o_pos_x     (w_pos_x),
    .o_pos_y     (w_pos_y)
  );

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_home = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // respawn has priority; a coincident tick is simply dropped
        if (respawn)   w_home = 1'b1;
        else if (tick) w_next = ST_ISSUE;
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_we = 1'b1;
          if (r_idx == LAST_IDX) begin
`ifdef SPRITE_COLLISION_EN
            w_next = ST_CHECK;
`else
            w_next = ST_DONE;
`endif
          end else begin
            w_next = ST_ISSUE;
          end
        end
      end
      ST_CHECK: w_next = ST_DONE;
      ST_DONE: begin
        w_next = ST_IDLE;
        // a respawn seen during the sweep (or right now) overrides its results
        w_home = r_pend | respawn;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (tick && !respawn) begin
            r_snap <= dir_in;
            r_idx  <= '0;
          end
        end
        ST_ISSUE: r_cnt <= CNT_W'(UPD_LATENCY - 1);
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
      if (r_state == ST_DONE)                  r_pend <= 1'b0;
      else if (respawn && r_state != ST_IDLE)  r_pend <= 1'b1;
    end
  end

  // Operands stay stable from ISSUE through the end of WAIT so any latency of update unit works.
  always_comb begin
    upd_pos_x  = '0;
    upd_pos_y  = '0;
    upd_dir    = '0;
    upd_sprite = '0;
    if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
      upd_pos_x  = w_pos_x[r_idx*X_W +: X_W];
      upd_pos_y  = w_pos_y[r_idx*Y_W +: Y_W];
      upd_dir    = r_snap[r_idx*DIR_W +: DIR_W];
      upd_sprite = r_idx;
    end
  end

  assign pos_x   = w_pos_x;
  assign pos_y   = w_pos_y;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign overrun = tick & busy;

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-2:0] r_coll;
  logic [NUM_SPRITES-2:0] w_coll;

  always_comb begin
    w_coll = '0;
    for (int k = 1; k < NUM_SPRITES; k++) begin
      w_coll[k-1] = (tile_x(w_pos_x[X_W-1:0]) == tile_x(w_pos_x[k*X_W +: X_W])) &&
                    (tile_y(w_pos_y[Y_W-1:0]) == tile_y(w_pos_y[k*Y_W +: Y_W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_coll <= '0;
    else if (r_state == ST_CHECK)  r_coll <= w_coll;
  end

  assign collision = r_coll;
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// tb/tb_sprite_move_scheduler.sv - directed self-checking bench for sprite_move_scheduler
module tb_sprite_move_scheduler;

`ifdef SPRITE_COLLISION_EN
  localparam int          DC       = 12;
  localparam logic [3:0]  EXP_COLL = 4'b0100;
`else
  localparam int          DC       = 11;
  localparam logic [3:0]  EXP_COLL = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        respawn;
  logic [19:0] dir_in;
  logic [10:0] upd_pos_x;
  logic [9:0]  upd_pos_y;
  logic [3:0]  upd_dir;
  logic [2:0]  upd_sprite;
  logic [10:0] upd_new_x = '0;
  logic [9:0]  upd_new_y = '0;
  logic [54:0] pos_x;
  logic [49:0] pos_y;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [3:0]  collision;

  always #5 clk = ~clk;

  sprite_move_scheduler #(.UPD_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .respawn    (respawn),
    .dir_in     (dir_in),
    .upd_pos_x  (upd_pos_x),
    .upd_pos_y  (upd_pos_y),
    .upd_dir    (upd_dir),
    .upd_sprite (upd_sprite),
    .upd_new_x  (upd_new_x),
    .upd_new_y  (upd_new_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .collision  (collision)
  );

  // Behavioural update unit, latency 1, 16 px step, horizontal tunnel 343 <-> 1607.
  // The override lets the bench place pacman anywhere.
  logic        ovr_en = 1'b0;
  logic [10:0] ovr_x  = '0;
  logic [9:0]  ovr_y  = '0;

  always @(posedge clk) begin
    if (ovr_en && upd_sprite == 3'd0) begin
      upd_new_x <= ovr_x;
      upd_new_y <= ovr_y;
    end else begin
      upd_new_x <= upd_pos_x;
      upd_new_y <= upd_pos_y;
      case (upd_dir)
        4'b1000: upd_new_x <= (upd_pos_x <= 11'd343) ? 11'd1607 : upd_pos_x - 11'd16;
        4'b0001: upd_new_x <= (upd_pos_x >= 11'd1607) ? 11'd343 : upd_pos_x + 11'd16;
        4'b0010: upd_new_y <= upd_pos_y - 10'd16;
        4'b0100: upd_new_y <= upd_pos_y + 10'd16;
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  int hx [5] = '{1367, 983, 967, 935, 999};
  int hy [5] = '{306, 210, 258, 258, 258};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int k, input int ex, input int ey);
    chk({tag, "_x"}, 64'(pos_x[k*11 +: 11]), 64'(ex));
    chk({tag, "_y"}, 64'(pos_y[k*10 +: 10]), 64'(ey));
  endtask

  task automatic chk_homes(input string tag);
    for (int k = 0; k < 5; k++) chk_pos($sformatf("%s_s%0d", tag, k), k, hx[k], hy[k]);
  endtask

  int         sw_done_c;
  int         sw_ndone;
  int         sw_nover;
  logic [3:0] sw_coll;
  logic [2:0] sw_spr  [17];
  logic       sw_busy [17];

  // Tick in cycle 0, then observe cycles 1..16; optional tick at cycle 3 and respawn at cycle 5.
  task automatic sweep(input logic [19:0] dirs, input logic [19:0] dirs_mid,
                       input bit t3, input bit r5);
    sw_done_c = 0;
    sw_ndone  = 0;
    sw_nover  = 0;
    sw_coll   = 4'hx;
    dir_in    = dirs;
    tick      = 1'b1;
    #1;
    if (overrun) sw_nover++;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) dir_in = dirs_mid;
      tick    = t3 && (c == 3);
      respawn = r5 && (c == 5);
      #1;
      sw_spr[c]  = upd_sprite;
      sw_busy[c] = busy;
      if (overrun) sw_nover++;
      if (done) begin
        sw_ndone++;
        if (sw_done_c == 0) begin
          sw_done_c = c;
          sw_coll   = collision;
        end
      end
      @(posedge clk); #1;
    end
    tick    = 1'b0;
    respawn = 1'b0;
  endtask

  task automatic place(input int x, input int y);
    ovr_en = 1'b1;
    ovr_x  = 11'(x);
    ovr_y  = 10'(y);
    sweep(20'h0, 20'h0, 1'b0, 1'b0);
    ovr_en = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    respawn = 1'b0;
    dir_in  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // reset state
    chk_homes("rst");
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_coll", 64'(collision), 64'd0);
    chk("rst_upd_sprite", 64'(upd_sprite), 64'd0);
    chk("rst_upd_x", 64'(upd_pos_x), 64'd0);

    // 1) all stay: done at cycle DC, positions unchanged
    sweep(20'h0, 20'h0, 1'b0, 1'b0);
    chk("t1_done_cycle", 64'(sw_done_c), 64'(DC));
    chk("t1_ndone", 64'(sw_ndone), 64'd1);
    chk("t1_nover", 64'(sw_nover), 64'd0);
    chk("t1_busy_c1", 64'(sw_busy[1]), 64'd1);
    chk("t1_busy_dc", 64'(sw_busy[DC]), 64'd1);
    chk("t1_busy_after", 64'(sw_busy[DC+1]), 64'd0);
    chk_homes("t1");

    // 2) pacman 455,146 moving left; service order 0..4, 2 cycles each
    place(455, 146);
    chk_pos("t2_place", 0, 455, 146);
    sweep(20'h00008, 20'h00008, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) chk($sformatf("t2_order_c%0d", c), 64'(sw_spr[c]), 64'((c - 1) / 2));
    chk_pos("t2_pac", 0, 439, 146);
    chk_pos("t2_blinky", 1, 983, 210);
    chk_pos("t2_clyde", 4, 999, 258);

    // 3) tunnel wrap right; dir change after tick only applies on the following sweep
    place(1607, 443);
    sweep(20'h00001, 20'h00008, 1'b0, 1'b0);
    chk_pos("t3_wrap", 0, 343, 443);
    sweep(20'h00008, 20'h00008, 1'b0, 1'b0);
    chk_pos("t3_next", 0, 1607, 443);

    // 4) tick mid-sweep -> overrun, one done; respawn mid-sweep -> homes after DONE
    sweep(20'h0, 20'h0, 1'b1, 1'b1);
    chk("t4_nover", 64'(sw_nover), 64'd1);
    chk("t4_ndone", 64'(sw_ndone), 64'd1);
    chk("t4_done_cycle", 64'(sw_done_c), 64'(DC));
    chk_homes("t4");

    // 5a) tick and respawn together while idle: homes, no sweep, no overrun
    place(455, 146);
    tick    = 1'b1;
    respawn = 1'b1;
    #1;
    chk("t5a_overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    tick    = 1'b0;
    respawn = 1'b0;
    chk("t5a_busy", 64'(busy), 64'd0);
    chk_homes("t5a");
    repeat (3) @(posedge clk);
    #1;
    chk("t5a_busy_later", 64'(busy), 64'd0);

    // 5b) reset in the middle of a sweep
    place(455, 146);
    dir_in = 20'h00008;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5b_busy", 64'(busy), 64'd0);
    chk("t5b_done", 64'(done), 64'd0);
    chk_homes("t5b");
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(20'h0, 20'h0, 1'b0, 1'b0);
    chk("t5b_resweep_done", 64'(sw_done_c), 64'(DC));
    chk_homes("t5b_after");

    // 6) pacman and inky on tile (37,14)
    place(940, 265);
    chk_pos("t6_pac", 0, 940, 265);
    chk("t6_coll_done", 64'(sw_coll), 64'(EXP_COLL));
    chk("t6_coll_held", 64'(collision), 64'(EXP_COLL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
